// File: rtl/ghostbus_host_bridge.sv
// Byte-stream command parser and ghostbus master: turns host write/read
// commands into single-cycle ghostbus strobes and streams the response bytes back.
module ghostbus_host_bridge #(
   parameter int AW       = 24,
   parameter int DW       = 32,
   parameter int RD_DELAY = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    rx_data,
   input  logic          rx_valid,
   output logic          rx_ready,
   output logic [7:0]    tx_data,
   output logic          tx_valid,
   input  logic          tx_ready,
   output logic [AW-1:0] gb_addr,
   output logic [DW-1:0] gb_dout,
   input  logic [DW-1:0] gb_din,
   output logic          gb_we,
   output logic          gb_re,
   output logic          busy
);

   localparam int AB = (AW + 7) / 8;
   localparam int DB = (DW + 7) / 8;
   localparam int RW = DB * 8;
   localparam logic [3:0] AB_LAST = 4'(AB - 1);
   localparam logic [3:0] DB_LAST = 4'(DB - 1);
   localparam logic [3:0] RD_LAST = 4'(RD_DELAY);

   localparam logic [7:0] OP_WR = 8'h57;
   localparam logic [7:0] OP_RD = 8'h52;
   localparam logic [7:0] ACK   = 8'h06;
   localparam logic [7:0] NAK   = 8'h15;

   // The byte counter is 4 bits, so field lengths and read latency must fit it.
   generate
      if (AB > 15 || DB > 15 || RD_DELAY < 1 || RD_DELAY > 15) begin : g_bad_cfg
         $error("ghostbus_host_bridge: AB/DB must be <= 15 and RD_DELAY in 1..15");
      end
   endgenerate

   typedef enum logic [3:0] {
      S_IDLE, S_ADDR, S_WDATA, S_BUS_WR, S_BUS_RD, S_RD_WAIT, S_TX_DATA, S_TX_ACK, S_TX_NAK
   } state_t;

   state_t          state, state_next;
   logic [3:0]      cnt;
   logic            is_wr;
   logic [AW-1:0]   addr_q;
   logic [DW-1:0]   data_q;
   logic [RW-1:0]   rd_q;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   // NOTE: every output gets a default before the case so no path infers a latch.
   always_comb begin
      state_next = state;
      rx_ready   = 1'b0;
      tx_valid   = 1'b0;
      tx_data    = 8'h00;
      gb_we      = 1'b0;
      gb_re      = 1'b0;
      case (state)
         S_IDLE: begin
            rx_ready = 1'b1;
            if (rx_valid)
               state_next = (rx_data == OP_WR || rx_data == OP_RD) ? S_ADDR : S_TX_NAK;
         end
         S_ADDR: begin
            rx_ready = 1'b1;
            if (rx_valid && cnt == AB_LAST) state_next = is_wr ? S_WDATA : S_BUS_RD;
         end
         S_WDATA: begin
            rx_ready = 1'b1;
            if (rx_valid && cnt == DB_LAST) state_next = S_BUS_WR;
         end
         S_BUS_WR: begin
            gb_we      = 1'b1;
            state_next = S_TX_ACK;
         end
         S_BUS_RD: begin
            gb_re      = 1'b1;
            state_next = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (cnt == RD_LAST) state_next = S_TX_DATA;
         end
         S_TX_DATA: begin
            tx_valid = 1'b1;
            tx_data  = rd_q[RW-1 -: 8];
            if (tx_ready && cnt == DB_LAST) state_next = S_IDLE;
         end
         S_TX_ACK: begin
            tx_valid = 1'b1;
            tx_data  = ACK;
            if (tx_ready) state_next = S_IDLE;
         end
         S_TX_NAK: begin
            tx_valid = 1'b1;
            tx_data  = NAK;
            if (tx_ready) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Datapath: shift registers and the shared byte / latency counter.
   // NOTE: these registers are small and host-visible, so all of them are reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         is_wr  <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         rd_q   <= '0;
      end else begin
         case (state)
            S_IDLE: if (rx_valid) begin
               is_wr <= (rx_data == OP_WR);
               cnt   <= '0;
            end
            S_ADDR: if (rx_valid) begin
               addr_q <= AW'({addr_q, rx_data});
               cnt    <= (cnt == AB_LAST) ? 4'd0 : cnt + 4'd1;
            end
            S_WDATA: if (rx_valid) begin
               data_q <= DW'({data_q, rx_data});
               cnt    <= (cnt == DB_LAST) ? 4'd0 : cnt + 4'd1;
            end
            // cnt counts cycles since the read strobe; capture lands on cycle T+RD_DELAY.
            S_BUS_RD: cnt <= 4'd1;
            S_RD_WAIT: begin
               if (cnt == RD_LAST) begin
                  rd_q <= RW'(gb_din);
                  cnt  <= '0;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            S_TX_DATA: if (tx_ready) begin
               rd_q <= rd_q << 8;
               cnt  <= (cnt == DB_LAST) ? 4'd0 : cnt + 4'd1;
            end
            default: ;
         endcase
      end
   end

   assign gb_addr = addr_q;
   assign gb_dout = data_q;
   assign busy    = (state != S_IDLE);

endmodule

// File: tb/tb_ghostbus_host_bridge.sv
// Self-checking bench for ghostbus_host_bridge: a 24/32-bit bridge plus a 12/8-bit
// bridge, each with a latency-accurate ghostbus slave; table, corner and random tests.
module tb_ghostbus_host_bridge;

   localparam int RD_DELAY = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       sel;
   logic [7:0] rx_data;
   logic       rx_valid, tx_ready;

   logic        rx_ready_a, tx_valid_a, gb_we_a, gb_re_a, busy_a;
   logic [7:0]  tx_data_a;
   logic [23:0] gb_addr_a;
   logic [31:0] gb_dout_a, gb_din_a;

   logic        rx_ready_b, tx_valid_b, gb_we_b, gb_re_b, busy_b;
   logic [7:0]  tx_data_b;
   logic [11:0] gb_addr_b;
   logic [7:0]  gb_dout_b, gb_din_b;

   ghostbus_host_bridge #(.AW(24), .DW(32), .RD_DELAY(RD_DELAY)) u_dut (
      .clk(clk), .rst(rst),
      .rx_data(rx_data), .rx_valid(rx_valid & ~sel), .rx_ready(rx_ready_a),
      .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready & ~sel),
      .gb_addr(gb_addr_a), .gb_dout(gb_dout_a), .gb_din(gb_din_a),
      .gb_we(gb_we_a), .gb_re(gb_re_a), .busy(busy_a)
   );

   ghostbus_host_bridge #(.AW(12), .DW(8), .RD_DELAY(RD_DELAY)) u_small (
      .clk(clk), .rst(rst),
      .rx_data(rx_data), .rx_valid(rx_valid & sel), .rx_ready(rx_ready_b),
      .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready & sel),
      .gb_addr(gb_addr_b), .gb_dout(gb_dout_b), .gb_din(gb_din_b),
      .gb_we(gb_we_b), .gb_re(gb_re_b), .busy(busy_b)
   );

   // Observed view of whichever bridge is selected
   logic        rx_ready_o, tx_valid_o, gb_we_o, gb_re_o, busy_o;
   logic [7:0]  tx_data_o;
   logic [23:0] gb_addr_o;
   logic [31:0] gb_dout_o;
   assign rx_ready_o = sel ? rx_ready_b : rx_ready_a;
   assign tx_valid_o = sel ? tx_valid_b : tx_valid_a;
   assign tx_data_o  = sel ? tx_data_b  : tx_data_a;
   assign gb_we_o    = sel ? gb_we_b    : gb_we_a;
   assign gb_re_o    = sel ? gb_re_b    : gb_re_a;
   assign busy_o     = sel ? busy_b     : busy_a;
   assign gb_addr_o  = sel ? {12'h000, gb_addr_b} : gb_addr_a;
   assign gb_dout_o  = sel ? {24'h0, gb_dout_b}   : gb_dout_a;

   // Ghostbus slaves: read data is valid only in cycle T+RD_DELAY, junk otherwise
   logic [31:0] mem_a [int];
   logic [7:0]  mem_b [int];
   logic [15:0] re_pipe_a, re_pipe_b;

   function automatic logic [31:0] rd_a(input int a);
      return mem_a.exists(a) ? mem_a[a] : 32'h0;
   endfunction
   function automatic logic [7:0] rd_b(input int a);
      return mem_b.exists(a) ? mem_b[a] : 8'h0;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         re_pipe_a <= '0;
         re_pipe_b <= '0;
      end else begin
         re_pipe_a <= {re_pipe_a[14:0], gb_re_a};
         re_pipe_b <= {re_pipe_b[14:0], gb_re_b};
         if (gb_we_a) mem_a[int'(gb_addr_a)] = gb_dout_a;
         if (gb_we_b) mem_b[int'(gb_addr_b)] = gb_dout_b;
      end
   end

   always @(negedge clk) begin
      gb_din_a <= re_pipe_a[RD_DELAY-1] ? rd_a(int'(gb_addr_a)) : 32'hA5A5_A5A5;
      gb_din_b <= re_pipe_b[RD_DELAY-1] ? rd_b(int'(gb_addr_b)) : 8'hA5;
   end

   // Strobe monitor (sampled mid-cycle)
   int          cyc = 0;
   int          we_cnt = 0, re_cnt = 0, strobe_err = 0;
   int          we_cyc, re_cyc, txv_cyc, last_acc;
   logic [23:0] we_addr;
   logic [31:0] we_dout;
   logic        prev_we, prev_re, prev_txv;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (rst) begin
         prev_we = 1'b0; prev_re = 1'b0; prev_txv = 1'b0;
      end else begin
         if (gb_we_o) begin
            we_cnt++; we_cyc = cyc; we_addr = gb_addr_o; we_dout = gb_dout_o;
         end
         if (gb_re_o) begin
            re_cnt++; re_cyc = cyc;
         end
         if ((gb_we_o && gb_re_o) || (gb_we_o && prev_we) || (gb_re_o && prev_re)) strobe_err++;
         if (tx_valid_o && !prev_txv) txv_cyc = cyc;
         prev_we = gb_we_o; prev_re = gb_re_o; prev_txv = tx_valid_o;
      end
   end

   int n_checks = 0, n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      rx_data = b; rx_valid = 1'b1;
      while (!rx_ready_o && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) begin
         n_checks++; n_fail++;
         $display("FAIL send_timeout: rx_ready stayed 0 for byte 0x%0h", b);
      end
      last_acc = cyc;
      @(posedge clk); #1 rx_valid = 1'b0;
   endtask

   task automatic recv_byte(output logic [7:0] b, input int stall);
      int n = 0;
      b = 8'h00;
      @(negedge clk);
      while (!tx_valid_o && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) begin
         n_checks++; n_fail++;
         $display("FAIL recv_timeout: tx_valid stayed 0");
         return;
      end
      repeat (stall) @(negedge clk);
      b = tx_data_o; tx_ready = 1'b1;
      @(posedge clk); #1 tx_ready = 1'b0;
   endtask

   task automatic send_cmd(input logic [7:0] op, input logic [23:0] addr, input logic [31:0] data);
      int ab, db;
      ab = sel ? 2 : 3;
      db = sel ? 1 : 4;
      send_byte(op);
      if (op == 8'h57 || op == 8'h52)
         for (int i = 0; i < ab; i++) send_byte(addr[8*(ab-1-i) +: 8]);
      if (op == 8'h57)
         for (int i = 0; i < db; i++) send_byte(data[8*(db-1-i) +: 8]);
   endtask

   task automatic recv_resp(output logic [31:0] v, input int nbytes, input int stall);
      logic [7:0] b;
      v = 32'h0;
      for (int i = 0; i < nbytes; i++) begin
         recv_byte(b, stall);
         v = {v[23:0], b};
      end
   endtask

   typedef struct {
      logic [7:0]  op;
      logic [23:0] addr;
      logic [31:0] data;
      int          nresp;
      logic [31:0] resp;
      int          dwe;
      int          dre;
   } vec_t;

   localparam int NV = 8;
   vec_t vecs [NV];

   logic [31:0] exp_mem [int];
   logic [31:0] resp;
   logic [7:0]  b;
   int          we0, re0;

   initial begin
      vecs[0] = '{8'h57, 24'h000100, 32'hDEADBEEF, 1, 32'h06,       1, 0};
      vecs[1] = '{8'h52, 24'h000004, 32'h0,        4, 32'h12345678, 0, 1};
      vecs[2] = '{8'h41, 24'h000000, 32'h0,        1, 32'h15,       0, 0};
      vecs[3] = '{8'h52, 24'h000004, 32'h0,        4, 32'h12345678, 0, 1};
      vecs[4] = '{8'h52, 24'h000100, 32'h0,        4, 32'hDEADBEEF, 0, 1};
      vecs[5] = '{8'h57, 24'hFFFFFF, 32'h00000001, 1, 32'h06,       1, 0};
      vecs[6] = '{8'h52, 24'hFFFFFF, 32'h0,        4, 32'h00000001, 0, 1};
      vecs[7] = '{8'hFF, 24'h000000, 32'h0,        1, 32'h15,       0, 0};

      mem_a[4]   = 32'h12345678;
      exp_mem[4] = 32'h12345678;

      rst = 1'b1; sel = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_rx_ready", rx_ready_a, 1);
      check("reset_busy", busy_a, 0);
      check("reset_tx_valid", tx_valid_a, 0);
      check("reset_gb_addr", gb_addr_a, 0);
      rst = 1'b0;
      @(negedge clk);
      check("post_reset_strobes", {30'h0, gb_we_a, gb_re_a}, 0);

      // Table-driven commands on the 24/32 bridge
      for (int i = 0; i < NV; i++) begin
         we0 = we_cnt; re0 = re_cnt;
         send_cmd(vecs[i].op, vecs[i].addr, vecs[i].data);
         recv_resp(resp, vecs[i].nresp, i % 3);
         check($sformatf("vec%0d_resp", i), resp, vecs[i].resp);
         check($sformatf("vec%0d_we_count", i), we_cnt - we0, vecs[i].dwe);
         check($sformatf("vec%0d_re_count", i), re_cnt - re0, vecs[i].dre);
         if (vecs[i].dwe == 1) begin
            check($sformatf("vec%0d_we_addr", i), we_addr, vecs[i].addr);
            check($sformatf("vec%0d_we_data", i), we_dout, vecs[i].data);
            check($sformatf("vec%0d_we_turnaround", i), we_cyc - last_acc, 1);
            exp_mem[int'(vecs[i].addr)] = vecs[i].data;
         end
         if (vecs[i].dre == 1) begin
            check($sformatf("vec%0d_re_turnaround", i), re_cyc - last_acc, 1);
            check($sformatf("vec%0d_first_tx", i), txv_cyc - re_cyc, RD_DELAY + 1);
         end
      end

      // Backpressure on the read response, then back-to-back acceptance
      send_cmd(8'h52, 24'h000004, 32'h0);
      begin
         int n = 0;
         @(negedge clk);
         while (!tx_valid_o && n < 200) begin @(negedge clk); n++; end
         for (int k = 0; k < 10; k++) begin
            check("bp_tx_data", tx_data_o, 8'h12);
            check("bp_tx_valid", tx_valid_o, 1);
            check("bp_rx_ready", rx_ready_o, 0);
            @(negedge clk);
         end
      end
      recv_resp(resp, 4, 0);
      check("bp_resp", resp, 32'h12345678);
      @(negedge clk);
      check("b2b_rx_ready", rx_ready_o, 1);
      check("b2b_busy", busy_o, 0);

      // Reset in the middle of a write
      we0 = we_cnt;
      send_byte(8'h57); send_byte(8'h00); send_byte(8'h01);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_busy", busy_a, 0);
      check("mid_rst_rx_ready", rx_ready_a, 1);
      check("mid_rst_tx_valid", tx_valid_a, 0);
      check("mid_rst_gb_addr", gb_addr_a, 0);
      check("mid_rst_gb_dout", gb_dout_a, 0);
      @(negedge clk);
      rst = 1'b0;
      send_cmd(8'h57, 24'h000200, 32'hCAFEF00D);
      recv_resp(resp, 1, 1);
      exp_mem[32'h200] = 32'hCAFEF00D;
      check("after_rst_ack", resp, 8'h06);
      check("after_rst_we_count", we_cnt - we0, 1);
      check("after_rst_we_addr", we_addr, 24'h000200);

      // Narrow configuration: AW=12, DW=8
      sel = 1'b1;
      we0 = we_cnt; re0 = re_cnt;
      send_cmd(8'h57, 24'h000ABC, 32'h5A);
      recv_resp(resp, 1, 0);
      check("small_ack", resp, 8'h06);
      check("small_we_addr", we_addr, 24'h000ABC);
      check("small_we_data", we_dout, 32'h5A);
      send_cmd(8'h52, 24'h000ABC, 32'h0);
      recv_resp(resp, 1, 2);
      check("small_read", resp, 8'h5A);
      check("small_strobes", (we_cnt - we0) * 16 + (re_cnt - re0), 32'h11);
      sel = 1'b0;

      // Random commands against a memory-level reference model
      for (int i = 0; i < 40; i++) begin
         int          kind;
         logic [23:0] a;
         logic [31:0] d, exp_resp;
         logic [7:0]  op;
         kind = int'($urandom_range(0, 9));
         a    = 24'h000300 + 24'($urandom_range(0, 5));
         d    = $urandom;
         we0  = we_cnt;
         if (kind < 4) begin
            op = 8'h57; exp_resp = 32'h06;
         end else if (kind < 9) begin
            op = 8'h52;
            exp_resp = exp_mem.exists(int'(a)) ? exp_mem[int'(a)] : 32'h0;
         end else begin
            op = 8'($urandom_range(0, 8'h50));
            exp_resp = 32'h15;
         end
         send_cmd(op, a, d);
         recv_resp(resp, (op == 8'h52) ? 4 : 1, int'($urandom_range(0, 3)));
         check($sformatf("rand%0d_op%0h_resp", i, op), resp, exp_resp);
         check($sformatf("rand%0d_we_count", i), we_cnt - we0, (op == 8'h57) ? 1 : 0);
         if (op == 8'h57) exp_mem[int'(a)] = d;
      end

      check("strobe_rules", strobe_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ghostbus_host_bridge.md
Name: ghostbus_host_bridge

Overview:
Byte-stream command parser and ghostbus master. It sits directly upstream of the auto-decoded ghostbus that serves host-accessible registers and RAMs in user modules. It turns serial-style host commands (read/write, address, data) into single-cycle ghostbus write/read strobes, then returns the response bytes. Typical feeders are a UART or USB FIFO byte interface.

Parameters:
AW, 24, ghostbus address width in bits; address field is AB = ceil(AW/8) bytes.
DW, 32, ghostbus data width in bits; data field is DB = ceil(DW/8) bytes.
RD_DELAY, 2, cycles from the gb_re strobe to valid gb_din; legal range 1..15.

Ports:
clk  input  1  system clock; all logic on the rising edge
rst  input  1  asynchronous reset, active-high
rx_data  input  8  command byte from host
rx_valid  input  1  rx_data valid
rx_ready  output  1  bridge accepts a byte when rx_valid & rx_ready
tx_data  output  8  response byte to host
tx_valid  output  1  tx_data valid
tx_ready  input  1  host consumes a byte when tx_valid & tx_ready
gb_addr  output  AW  ghostbus address
gb_dout  output  DW  ghostbus write data
gb_din  input  DW  ghostbus read data
gb_we  output  1  one-cycle write strobe
gb_re  output  1  one-cycle read strobe
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0 except rx_ready = 1. Internal address/data shift registers and byte counter are cleared.
- Command format, all fields MSB-first:
  - write: 0x57, AB address bytes, DB data bytes
  - read: 0x52, AB address bytes
- Wide fields: address bytes shift into a left-shifting register. Only the low AW bits drive gb_addr. Data is handled the same way with DW bits.
- States:
  - IDLE: rx_ready = 1. On an accepted byte of 0x57 or 0x52, latch the opcode, clear the counter and go to ADDR. On any other accepted byte, go to TX_NAK.
  - ADDR: rx_ready = 1. Shift each accepted byte in. After byte AB: a write goes to WDATA, a read goes to BUS_RD.
  - WDATA: rx_ready = 1. Shift bytes in. After byte DB, go to BUS_WR.
  - BUS_WR: rx_ready = 0. gb_we = 1 for exactly this one cycle, with gb_addr and gb_dout already stable. Next state is TX_ACK.
  - BUS_RD: gb_re = 1 for exactly this one cycle (call it cycle T). Next state is RD_WAIT.
  - RD_WAIT: counts cycles. Captures gb_din on the clock edge ending cycle T+RD_DELAY, then goes to TX_DATA.
  - TX_DATA: tx_valid = 1. Sends DB bytes, MSB first. Each byte stays held until tx_ready. After the last handshake, go to IDLE.
  - TX_ACK: tx_valid = 1 with tx_data = 0x06. After the handshake, go to IDLE.
  - TX_NAK: tx_valid = 1 with tx_data = 0x15. After the handshake, go to IDLE.
- rx_ready is 0 in every state other than IDLE, ADDR and WDATA. Bytes presented then are not consumed. The host is expected to wait.
- tx_valid stays 0 in IDLE, ADDR, WDATA, BUS_WR, BUS_RD and RD_WAIT. Once asserted, tx_data and tx_valid stay stable until the handshake.
- gb_addr and gb_dout update only while bytes shift in, and hold their values between commands. gb_we and gb_re are never high in the same cycle, and neither is ever high for more than one consecutive cycle.
- Turnaround:
  - write: gb_we fires exactly 1 cycle after the last data byte is accepted.
  - read: gb_re fires exactly 1 cycle after the last address byte is accepted. The first tx_valid comes RD_DELAY+1 cycles after gb_re.
- Back-to-back commands: a new opcode is accepted in the cycle after the final tx handshake. There is no cycle of idle penalty beyond the state change.
- Reset mid-command: every state returns to IDLE immediately. A partial command is discarded and no strobe is issued. A pending tx byte is dropped.
- The byte counter is 4 bits wide. AB and DB must each be 15 or less; an elaboration check enforces this.

Test Plan:
- Write: send 57 00 01 00 DE AD BE EF → one gb_we pulse with gb_addr = 0x000100 and gb_dout = 0xDEADBEEF; tx returns 0x06; no gb_re.
- Read with RD_DELAY = 2 and a model returning 0x12345678 from address 0x000004: send 52 00 00 04 → one gb_re; gb_din sampled 2 cycles later; tx returns 12 34 56 78 in order.
- Backpressure: hold tx_ready = 0 for 10 cycles during the read response → tx_data stays 0x12 and tx_valid stays high; rx_ready = 0 throughout; then the remaining bytes complete.
- Bad opcode: send 0x41 → tx returns 0x15; no gb_we or gb_re; the next command 52 00 00 04 works normally.
- Reset mid-write: assert rst after 57 00 01 → busy = 0 and all outputs at reset values; a following full write produces exactly one gb_we.
- AW = 12, DW = 8 configuration: send 57 0A BC 5A → gb_addr = 0xABC and gb_dout = 0x5A; a read of 0xABC returns one byte.
